// File: rtl/uc_secuenciador_if.sv
// Control-unit <-> datapath bundle: decoded instruction fields in, selects and strobes out.
// The control unit is the master; the datapath side is the slave.
interface uc_secuenciador_if #(
  parameter int DEPTH_W = 4
);
  logic [5:0]         opcode;
  logic               z;
  logic               resume;
  logic               s_inc;
  logic               selectorMuxSaltoR;
  logic               selectorMuxPilaSubRutinas;
  logic               pc_en;
  logic               s_inm;
  logic               s_mem;
  logic               we3;
  logic               wez;
  logic [2:0]         op_alu;
  logic               activarMemoria;
  logic               guardarMemoriaDatos;
  logic               selectorMuxDireccionMemoriaDatos;
  logic               activarPilaSubRutinas;
  logic               pushPilaSubRutinas;
  logic               halted;
  logic               stack_err;
  logic [DEPTH_W-1:0] sp_depth;

  modport master (
    input  opcode, z, resume,
    output s_inc, selectorMuxSaltoR, selectorMuxPilaSubRutinas, pc_en,
           s_inm, s_mem, we3, wez, op_alu,
           activarMemoria, guardarMemoriaDatos, selectorMuxDireccionMemoriaDatos,
           activarPilaSubRutinas, pushPilaSubRutinas,
           halted, stack_err, sp_depth
  );

  modport slave (
    output opcode, z, resume,
    input  s_inc, selectorMuxSaltoR, selectorMuxPilaSubRutinas, pc_en,
           s_inm, s_mem, we3, wez, op_alu,
           activarMemoria, guardarMemoriaDatos, selectorMuxDireccionMemoriaDatos,
           activarPilaSubRutinas, pushPilaSubRutinas,
           halted, stack_err, sp_depth
  );
endinterface

// File: rtl/uc_secuenciador.sv
// Control unit for the 8-bit processor: opcode decode, two-cycle load sequencing,
// HALT/resume and return-stack depth tracking with sticky overflow/underflow error.
module uc_secuenciador #(
  parameter int STACK_DEPTH = 8,
  parameter int DEPTH_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  uc_secuenciador_if.master bus
);

  localparam logic [1:0] EXEC    = 2'd0;
  localparam logic [1:0] LOAD_WB = 2'd1;
  localparam logic [1:0] HALT    = 2'd2;

  localparam logic [5:0] OP_J    = 6'b000000;
  localparam logic [5:0] OP_JZ   = 6'b000001;
  localparam logic [5:0] OP_JNZ  = 6'b000010;
  localparam logic [5:0] OP_JR   = 6'b000011;
  localparam logic [5:0] OP_CALL = 6'b000100;
  localparam logic [5:0] OP_RET  = 6'b000101;
  localparam logic [5:0] OP_HALT = 6'b000110;

  localparam logic [DEPTH_W-1:0] STACK_FULL = DEPTH_W'(STACK_DEPTH);

  logic [1:0]         state, nextState;
  logic [DEPTH_W-1:0] spDepth;
  logic               stackErr;
  logic               depthInc, depthDec, setErr;

  logic       sInc, saltoR, pilaSel, pcEn, sInm, sMem, we3, wez;
  logic [2:0] opAlu;
  logic       actMem, guardarMem, selDir, actPila, pushPila, haltedC;

  always_comb begin
    // NOTE: every output starts at 0 so no path can infer a latch, and so the
    // reset branch below only has to skip the decode to force all outputs low.
    sInc       = 1'b0;
    saltoR     = 1'b0;
    pilaSel    = 1'b0;
    pcEn       = 1'b0;
    sInm       = 1'b0;
    sMem       = 1'b0;
    we3        = 1'b0;
    wez        = 1'b0;
    opAlu      = 3'b000;
    actMem     = 1'b0;
    guardarMem = 1'b0;
    selDir     = 1'b0;
    actPila    = 1'b0;
    pushPila   = 1'b0;
    haltedC    = 1'b0;
    nextState  = state;
    depthInc   = 1'b0;
    depthDec   = 1'b0;
    setErr     = 1'b0;

    // Outputs are combinational, so reset must gate them to stay low asynchronously.
    if (!reset) begin
      case (state)
        EXEC: begin
          pcEn = 1'b1;
          sInc = 1'b1;
          casez (bus.opcode)
            6'b1?????: begin
              opAlu = bus.opcode[4:2];
              we3   = 1'b1;
              wez   = 1'b1;
            end
            6'b0100??: begin
              we3  = 1'b1;
              sInm = 1'b1;
            end
            6'b0101??: begin
              actMem     = 1'b1;
              guardarMem = 1'b1;
            end
            6'b01110?: begin
              actMem    = 1'b1;
              selDir    = 1'b1;
              pcEn      = 1'b0;
              nextState = LOAD_WB;
            end
            OP_J:   sInc   = 1'b0;
            OP_JZ:  sInc   = ~bus.z;
            OP_JNZ: sInc   = bus.z;
            OP_JR:  saltoR = 1'b1;
            OP_CALL: begin
              if (spDepth == STACK_FULL) begin
                pcEn      = 1'b0;
                setErr    = 1'b1;
                nextState = HALT;
              end else begin
                sInc     = 1'b0;
                actPila  = 1'b1;
                pushPila = 1'b1;
                depthInc = 1'b1;
              end
            end
            OP_RET: begin
              if (spDepth == '0) begin
                pcEn      = 1'b0;
                setErr    = 1'b1;
                nextState = HALT;
              end else begin
                actPila  = 1'b1;
                pilaSel  = 1'b1;
                depthDec = 1'b1;
              end
            end
            OP_HALT: begin
              pcEn      = 1'b0;
              nextState = HALT;
            end
            default: ;
          endcase
        end
        LOAD_WB: begin
          actMem    = 1'b1;
          selDir    = 1'b1;
          sMem      = 1'b1;
          we3       = 1'b1;
          pcEn      = 1'b1;
          sInc      = 1'b1;
          nextState = EXEC;
        end
        HALT: begin
          haltedC = 1'b1;
          // Resuming steps PC+1 past the HALT word; a stack fault can only be left by reset.
          if (bus.resume && !stackErr) begin
            pcEn      = 1'b1;
            sInc      = 1'b1;
            nextState = EXEC;
          end
        end
        default: nextState = EXEC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EXEC;
      spDepth  <= '0;
      stackErr <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples values from before the edge.
      state <= nextState;
      if (depthInc)      spDepth <= spDepth + DEPTH_W'(1);
      else if (depthDec) spDepth <= spDepth - DEPTH_W'(1);
      if (setErr)        stackErr <= 1'b1;
    end
  end

  assign bus.s_inc                            = sInc;
  assign bus.selectorMuxSaltoR                = saltoR;
  assign bus.selectorMuxPilaSubRutinas        = pilaSel;
  assign bus.pc_en                            = pcEn;
  assign bus.s_inm                            = sInm;
  assign bus.s_mem                            = sMem;
  assign bus.we3                              = we3;
  assign bus.wez                              = wez;
  assign bus.op_alu                           = opAlu;
  assign bus.activarMemoria                   = actMem;
  assign bus.guardarMemoriaDatos              = guardarMem;
  assign bus.selectorMuxDireccionMemoriaDatos = selDir;
  assign bus.activarPilaSubRutinas            = actPila;
  assign bus.pushPilaSubRutinas               = pushPila;
  assign bus.halted                           = haltedC;
  assign bus.stack_err                        = stackErr;
  assign bus.sp_depth                         = spDepth;

endmodule

// File: doc/uc_secuenciador.md
Name: uc_secuenciador

Overview:
- Control unit for the 8-bit processor datapath (10-bit PC, 16-bit instruction word, 16x8 register file, 128x8 data memory, subroutine return stack).
- Decodes the 6-bit opcode and the Z flag, and drives every datapath select and strobe.
- Sequences two-cycle loads through a PC-hold FSM and supports HALT/resume.
- Tracks return-stack depth and halts on stack overflow or underflow.

Parameters:
- STACK_DEPTH, 8: number of entries in the return stack.
- DEPTH_W, 4: width of the depth counter; must hold the value STACK_DEPTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction bits [15:10].
- z  in  1  registered zero flag from the datapath.
- resume  in  1  level; leaves HALT (sampled only in HALT).
- s_inc  out  1  0 = PC source is the absolute address in instruction [9:0]; 1 = PC source is the adder.
- selectorMuxSaltoR  out  1  adder increment: 0 = +1, 1 = +instr[9:0] (relative jump).
- selectorMuxPilaSubRutinas  out  1  1 = PC loads the stack top.
- pc_en  out  1  PC load enable; 0 holds the PC.
- s_inm  out  1  register write data = instr[11:4] immediate.
- s_mem  out  1  register write data = data-memory output.
- we3  out  1  register-file write enable.
- wez  out  1  Z flip-flop load enable.
- op_alu  out  3  ALU operation.
- activarMemoria  out  1  data-memory enable.
- guardarMemoriaDatos  out  1  data-memory write.
- selectorMuxDireccionMemoriaDatos  out  1  address source: 0 = instr[6:0], 1 = instr[10:4].
- activarPilaSubRutinas  out  1  stack operation enable.
- pushPilaSubRutinas  out  1  1 = push, 0 = pop.
- halted  out  1  FSM is in HALT.
- stack_err  out  1  sticky stack overflow/underflow flag.
- sp_depth  out  DEPTH_W  current stack depth.

Behaviour:
- Reset: clk and reset are the clock and reset ports. Reset is asynchronous and active-high. While reset is high, every output is 0, state = EXEC, sp_depth = 0, stack_err = 0.
- FSM states: EXEC, LOAD_WB, HALT.
- Outputs are combinational from the current state, opcode and z. Registered items: state, sp_depth, stack_err.
- Defaults in EXEC: pc_en=1, s_inc=1, selectorMuxSaltoR=0, selectorMuxPilaSubRutinas=0 (PC+1). All strobes 0.
- Opcode decode, in EXEC:
  - 1xxxxx, ALU: op_alu=opcode[4:2], we3=1, wez=1.
  - 0100xx, LI: we3=1, s_inm=1.
  - 0101xx, STORE: activarMemoria=1, guardarMemoriaDatos=1, selectorMuxDireccionMemoriaDatos=0.
  - 01110x, LOAD: activarMemoria=1, selectorMuxDireccionMemoriaDatos=1, pc_en=0; next state LOAD_WB.
  - 000000, J: s_inc=0.
  - 000001, JZ: s_inc=~z.
  - 000010, JNZ: s_inc=z.
  - 000011, JR: selectorMuxSaltoR=1. Offset is added modulo 1024.
  - 000100, CALL: s_inc=0, activarPilaSubRutinas=1, pushPilaSubRutinas=1; sp_depth+1. The pushed value is PC+1.
  - 000101, RET: activarPilaSubRutinas=1, pushPilaSubRutinas=0, selectorMuxPilaSubRutinas=1; sp_depth-1.
  - 000110, HALT: pc_en=0; next state HALT.
  - All other opcodes: NOP (PC+1).
- LOAD_WB (exactly 1 cycle):
  - Outputs: activarMemoria=1, selectorMuxDireccionMemoriaDatos=1, s_mem=1, we3=1, pc_en=1, s_inc=1.
  - Next state: EXEC. Load latency = 2 cycles; all other instructions take 1 cycle.
- HALT:
  - halted=1, pc_en=0, all strobes 0.
  - resume=1 and stack_err=0: for one cycle pc_en=1 with PC+1 selected (skips the HALT word); next state EXEC.
  - resume is ignored while stack_err=1; only reset clears stack_err.
- Overflow: CALL with sp_depth==STACK_DEPTH suppresses the push and jump (pc_en=0, activarPilaSubRutinas=0), sets stack_err, and moves to HALT.
- Underflow: RET with sp_depth==0 does the same (no pop, PC held, stack_err set, HALT).
- sp_depth never wraps.
- Reset during LOAD_WB or HALT aborts the operation immediately; no register write occurs after reset assertion.

Test Plan:
- ALU then JZ: ALU op 100 with result 0, then JZ to address 0x155. Required: wez=1 in the ALU cycle; JZ cycle s_inc=0; PC=0x155 next cycle. Repeat with z=0: PC advances by 1.
- LOAD from address 0x2A to R5 (data memory holds 0x7E). Required: cycle 1 pc_en=0, we3=0; cycle 2 s_mem=1, we3=1; R5=0x7E; PC advanced exactly once.
- CALL 0x040 at PC=0x010, then RET at 0x040. Required: sp_depth 0->1->0; PC 0x040, then 0x011.
- Nine nested CALLs with STACK_DEPTH=8. Required: ninth CALL gives no push, PC held, stack_err=1, halted=1. Pulsing resume has no effect; reset clears everything.
- RET at sp_depth=0. Required: stack_err=1, halted=1, activarPilaSubRutinas stays 0.
- HALT at PC=0x020. Required: PC stays 0x020 for 5 cycles; resume pulse gives PC=0x021 and halted=0. Reset asserted mid-LOAD (in LOAD_WB) gives outputs 0 asynchronously and no register write.
